// File: rtl/product_display_driver_if.sv
// Bundles the product/load/scroll controls and the decoder-facing outputs
// of the product display driver.
interface product_display_driver_if;
  logic        load;
  logic [15:0] product;
  logic        scroll_left;
  logic        scroll_right;
  logic        busy;
  logic [1:0]  toggle;
  logic [3:0]  digit;

  modport master (
    output load, product, scroll_left, scroll_right,
    input  busy, toggle, digit
  );

  modport slave (
    input  load, product, scroll_left, scroll_right,
    output busy, toggle, digit
  );
endinterface

// File: rtl/product_display_driver.sv
// Signed 16-bit product to 5-digit BCD (shift-add-3) with a scrollable
// 4-character window time-multiplexed onto a 7-segment decoder.
module product_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input logic                     clk,
  input logic                     rst_n,
  product_display_driver_if.slave bus
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RC_MAX = RW'(REFRESH_DIV - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_busy;
  logic          r_neg;
  logic          r_sign;
  logic [15:0]   r_mag;
  logic [19:0]   r_scratch;
  logic [3:0]    r_cnt;
  logic [19:0]   r_bcd;
  logic [1:0]    r_w;
  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_toggle;

  logic          w_start;
  logic          w_last;
  logic [15:0]   w_product_mag;
  logic [19:0]   w_adj;
  logic [19:0]   w_scratch_shift;
  logic [4:0]    w_nz;
  logic [4:0]    w_blank;
  logic [3:0]    w_char [6];
  logic [2:0]    w_idx;
  logic [3:0]    w_digit;

  assign w_start       = (r_state == S_IDLE) && bus.load;
  assign w_last        = (r_state == S_CONV) && (r_cnt == 4'd15);
  assign w_product_mag = bus.product[15] ? (~bus.product + 16'd1) : bus.product;

  // One double-dabble step: correct each nibble, then shift the next magnitude bit in.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5) ?
                                (r_scratch[gi*4 +: 4] + 4'd3) : r_scratch[gi*4 +: 4];
    end
  endgenerate
  assign w_scratch_shift = {w_adj[18:0], r_mag[15]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.load) w_state_next = S_CONV;
      S_CONV:  if (w_last)   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CONV);
  end
  assign bus.busy = w_busy;

  // Displayed digits and sign only change on the commit edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg     <= 1'b0;
      r_sign    <= 1'b0;
      r_mag     <= 16'd0;
      r_scratch <= 20'd0;
      r_cnt     <= 4'd0;
      r_bcd     <= 20'd0;
    end else if (w_start) begin
      r_neg     <= bus.product[15];
      r_mag     <= w_product_mag;
      r_scratch <= 20'd0;
      r_cnt     <= 4'd0;
    end else if (r_state == S_CONV) begin
      r_scratch <= w_scratch_shift;
      r_mag     <= {r_mag[14:0], 1'b0};
      r_cnt     <= r_cnt + 4'd1;
      if (w_last) begin
        r_bcd  <= w_scratch_shift;
        r_sign <= r_neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w <= 2'd0;
    end else if (bus.scroll_left && !bus.scroll_right && r_w != 2'd2) begin
      r_w <= r_w + 2'd1;
    end else if (bus.scroll_right && !bus.scroll_left && r_w != 2'd0) begin
      r_w <= r_w - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rcnt   <= '0;
      r_toggle <= 2'd0;
    end else if (r_rcnt == RC_MAX) begin
      r_rcnt   <= '0;
      r_toggle <= r_toggle + 2'd1;
    end else begin
      r_rcnt   <= r_rcnt + 1'b1;
    end
  end

  // A digit is blank when it and every more-significant digit are zero; D0 always shows.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_chars
      assign w_nz[gi] = |r_bcd[gi*4 +: 4];
      if (gi == 4) begin : g_top
        assign w_blank[gi] = ~w_nz[gi];
      end else if (gi == 0) begin : g_units
        assign w_blank[gi] = 1'b0;
      end else begin : g_mid
        assign w_blank[gi] = w_blank[gi+1] & ~w_nz[gi];
      end
      assign w_char[gi] = w_blank[gi] ? 4'd15 : r_bcd[gi*4 +: 4];
    end
  endgenerate
  assign w_char[5] = r_sign ? 4'd10 : 4'd15;

  assign w_idx = {1'b0, r_toggle} + {1'b0, r_w};

  always_comb begin
    w_digit = 4'd15;
    case (w_idx)
      3'd0:    w_digit = w_char[0];
      3'd1:    w_digit = w_char[1];
      3'd2:    w_digit = w_char[2];
      3'd3:    w_digit = w_char[3];
      3'd4:    w_digit = w_char[4];
      3'd5:    w_digit = w_char[5];
      default: w_digit = 4'd15;
    endcase
  end

  assign bus.toggle = r_toggle;
  assign bus.digit  = w_digit;

endmodule

// File: tb/tb_product_display_driver.sv
// Randomized bench for product_display_driver against an arithmetic model
// (decimal division for digits, cycle countdown for conversion latency).
module tb_product_display_driver;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  product_display_driver_if bus ();

  product_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_left = 0, m_pend = 0, m_val = 0, m_w = 0, m_rc = 0, m_tog = 0;
  bit m_pneg = 1'b0, m_neg = 1'b0;

  function automatic int pow10(int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic int exp_char(int val, bit neg, int k);
    int p;
    if (k == 5) return neg ? 10 : 15;
    p = pow10(k);
    if (k > 0 && val < p) return 15;
    return (val / p) % 10;
  endfunction

  function automatic int exp_digit();
    return exp_char(m_val, m_neg, m_tog + m_w);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: latency as a countdown, window and refresh as plain counters.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0; m_pend <= 0; m_pneg <= 1'b0; m_val <= 0; m_neg <= 1'b0;
      m_w <= 0; m_rc <= 0; m_tog <= 0;
    end else begin
      if (m_left == 0) begin
        if (bus.load === 1'b1) begin
          m_left <= 16;
          m_pend <= bus.product[15] ? (65536 - int'(bus.product)) : int'(bus.product);
          m_pneg <= bus.product[15];
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_val <= m_pend;
          m_neg <= m_pneg;
        end
      end
      if (bus.scroll_left && !bus.scroll_right)      m_w <= (m_w < 2) ? m_w + 1 : 2;
      else if (bus.scroll_right && !bus.scroll_left) m_w <= (m_w > 0) ? m_w - 1 : 0;
      if (m_rc == DIV - 1) begin
        m_rc  <= 0;
        m_tog <= (m_tog + 1) % 4;
      end else begin
        m_rc <= m_rc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.busy, (m_left > 0) ? 1 : 0);
      check("toggle", bus.toggle, m_tog);
      check("digit", bus.digit, exp_digit());
    end
  end

  task automatic lit_at_toggle(string name, int t, int exp_d);
    for (int i = 0; i < 16 && bus.toggle !== t[1:0]; i++) @(negedge clk);
    check({name, "_tog"}, bus.toggle, t);
    check(name, bus.digit, exp_d);
    check({name, "_model"}, exp_digit(), exp_d);
    $display("[TB] %s toggle=%0d digit=%0d", name, bus.toggle, bus.digit);
  endtask

  task automatic pulse(bit l, bit r);
    @(negedge clk);
    bus.scroll_left = l; bus.scroll_right = r;
    @(negedge clk);
    bus.scroll_left = 1'b0; bus.scroll_right = 1'b0;
  endtask

  task automatic wait_idle(string name, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({name, "_idle"}, bus.busy, 0);
  endtask

  task automatic load_run(string name, logic [15:0] p);
    int n;
    @(negedge clk);
    bus.load = 1'b1; bus.product = p;
    @(negedge clk);
    bus.load = 1'b0;
    wait_idle(name, n);
    check({name, "_busy_len"}, n, 16);
    $display("[TB] %s load=%h busy_cycles=%0d", name, p, n);
  endtask

  initial begin
    int n;
    bus.load = 1'b0; bus.product = 16'd0;
    bus.scroll_left = 1'b0; bus.scroll_right = 1'b0;

    // T1 / T6: reset, then toggle stepping and blank digits
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("t1_busy", bus.busy, 0);
    check("t1_toggle", bus.toggle, 0);
    check("t1_digit0", bus.digit, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("t6_toggle", bus.toggle, (k / 4) % 4);
      check("t1_digit", bus.digit, (((k / 4) % 4) == 0) ? 0 : 15);
    end

    // T2: -16384
    load_run("t2", 16'hC000);
    lit_at_toggle("t2_w0_t0", 0, 4);
    lit_at_toggle("t2_w0_t1", 1, 8);
    lit_at_toggle("t2_w0_t2", 2, 3);
    lit_at_toggle("t2_w0_t3", 3, 6);
    pulse(1, 0); pulse(1, 0);
    lit_at_toggle("t2_w2_t0", 0, 3);
    lit_at_toggle("t2_w2_t1", 1, 6);
    lit_at_toggle("t2_w2_t2", 2, 1);
    lit_at_toggle("t2_w2_t3", 3, 10);

    // T3: 255, window saturation and simultaneous pulses
    pulse(0, 1); pulse(0, 1);
    load_run("t3", 16'd255);
    lit_at_toggle("t3_t0", 0, 5);
    lit_at_toggle("t3_t1", 1, 5);
    lit_at_toggle("t3_t2", 2, 2);
    lit_at_toggle("t3_t3", 3, 15);
    pulse(1, 0); pulse(1, 0); pulse(1, 0);
    lit_at_toggle("t3_sat_t0", 0, 2);
    pulse(1, 1);
    lit_at_toggle("t3_both_t0", 0, 2);
    pulse(0, 1);
    lit_at_toggle("t3_w1_t0", 0, 5);

    // T4: -32768 with a load attempt during conversion
    pulse(0, 1); pulse(0, 1);
    @(negedge clk);
    bus.load = 1'b1; bus.product = 16'h8000;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    bus.load = 1'b1; bus.product = 16'h0001;
    @(negedge clk);
    bus.load = 1'b0;
    wait_idle("t4", n);
    lit_at_toggle("t4_d0", 0, 8);
    lit_at_toggle("t4_d1", 1, 6);
    lit_at_toggle("t4_d2", 2, 7);
    lit_at_toggle("t4_d3", 3, 2);
    pulse(1, 0); pulse(1, 0);
    lit_at_toggle("t4_d4", 2, 3);
    lit_at_toggle("t4_sign", 3, 10);

    // T5: reset mid-conversion
    @(negedge clk);
    bus.load = 1'b1; bus.product = 16'd12345;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_busy", bus.busy, 0);
    check("t5_toggle", bus.toggle, 0);
    check("t5_digit", bus.digit, 0);
    $display("[TB] t5 reset mid-conversion busy=%0d digit=%0d", bus.busy, bus.digit);

    // Randomized traffic checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n            = ($urandom_range(0, 599) != 0);
      bus.load         = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0:       bus.product = 16'h8000;
        1:       bus.product = 16'h0000;
        2:       bus.product = 16'hFFFF;
        default: bus.product = 16'($urandom);
      endcase
      bus.scroll_left  = ($urandom_range(0, 7) == 0);
      bus.scroll_right = ($urandom_range(0, 7) == 0);
      if (bus.load) $display("[TB] rand load=%h cycle=%0d", bus.product, c);
    end
    @(negedge clk);
    bus.load = 1'b0; bus.scroll_left = 1'b0; bus.scroll_right = 1'b0; rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
